// File: rtl/serializer_tx.sv
// -----------------------------------------------------------------------------
// serializer_tx
//   Parallel-to-serial frame transmitter. On an accepted start the word on
//   data_in is captured and sent LSB first on d, each bit held for BIT_CYCLES
//   clocks with en high. An optional even-parity bit follows the data. A single
//   DONE cycle (done=1) closes every frame, after which the block returns to
//   IDLE.
//
//   Optional feature: define PARITY_EN to append the even-parity bit
//   (XOR of all WIDTH data bits) after the last data bit.
//
// Parameters
//   WIDTH      : data bits per frame (2..16)
//   BIT_CYCLES : clocks each serial bit is held (1..16)
//
// Ports
//   clk     in   single clock, rising edge
//   reset   in   asynchronous, active-high reset
//   start   in   request to send, honoured only in IDLE
//   data_in in   parallel word, sampled only on the accepting edge
//   d       out  serial data, LSB first (registered)
//   en      out  bit-valid strobe for the downstream receiver (registered)
//   busy    out  high while a frame is on the line (registered)
//   done    out  one-cycle pulse after the last bit of a frame (registered)
// -----------------------------------------------------------------------------
module serializer_tx #(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             d,
  output logic             en,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Both counters are 4 bits wide so they cover the full legal ranges (max 15).
  localparam logic [3:0] CYC_LAST = 4'(BIT_CYCLES - 1);
  localparam logic [3:0] BIT_LAST = 4'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [3:0]       cyc_q, cyc_d;
  logic [3:0]       bit_q, bit_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             par_q, par_d;
  logic             serial_q, serial_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Even parity over the whole word.
  function automatic logic even_parity(input logic [WIDTH-1:0] word);
    even_parity = ^word;
  endfunction

  // Next-state and next-output logic. Outputs are computed from the state being
  // entered so that the registered pins change on the same edge as the state.
  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    par_d    = par_q;
    serial_d = 1'b0;
    en_d     = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SHIFT;
          shreg_d  = data_in;
          par_d    = even_parity(data_in);
          cyc_d    = 4'd0;
          bit_d    = 4'd0;
          serial_d = data_in[0];
          en_d     = 1'b1;
          busy_d   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end

      SHIFT: begin
        // shreg_q[0] always holds the bit currently on the line.
        serial_d = shreg_q[0];
        en_d     = 1'b1;
        busy_d   = 1'b1;
        if (cyc_q == CYC_LAST) begin
          cyc_d = 4'd0;
          if (bit_q == BIT_LAST) begin
            bit_d = 4'd0;
`ifdef PARITY_EN
            state_d  = PARITY;
            serial_d = par_q;
`else
            state_d  = DONE;
            serial_d = 1'b0;
            en_d     = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
`endif
          end else begin
            bit_d    = bit_q + 4'd1;
            shreg_d  = {1'b0, shreg_q[WIDTH-1:1]};
            serial_d = shreg_q[1];
          end
        end else begin
          cyc_d = cyc_q + 4'd1;
        end
      end

      PARITY: begin
        serial_d = par_q;
        en_d     = 1'b1;
        busy_d   = 1'b1;
        if (cyc_q == CYC_LAST) begin
          cyc_d    = 4'd0;
          state_d  = DONE;
          serial_d = 1'b0;
          en_d     = 1'b0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
        end else begin
          cyc_d = cyc_q + 4'd1;
        end
      end

      DONE: begin
        // Start is ignored here, guaranteeing one IDLE cycle between frames.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cyc_q    <= 4'd0;
      bit_q    <= 4'd0;
      shreg_q  <= '0;
      par_q    <= 1'b0;
      serial_q <= 1'b0;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      par_q    <= par_d;
      serial_q <= serial_d;
      en_q     <= en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign d    = serial_q;
  assign en   = en_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_serializer_tx.sv
// -----------------------------------------------------------------------------
// tb_serializer_tx
//   Directed bench for serializer_tx. Two instances: u_bc1 (WIDTH=8,
//   BIT_CYCLES=1) and u_bc3 (WIDTH=8, BIT_CYCLES=3). Outputs are compared
//   1 time unit after the rising edge as the packed vector {d, en, busy, done}.
//   Expectations follow PARITY_EN when the macro is defined.
// -----------------------------------------------------------------------------
module tb_serializer_tx;

`ifdef PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       start1, start3;
  logic [7:0] data1, data3;
  logic       d1, en1, busy1, done1;
  logic       d3, en3, busy3, done3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serializer_tx #(.WIDTH(8), .BIT_CYCLES(1)) u_bc1 (
    .clk(clk), .reset(reset), .start(start1), .data_in(data1),
    .d(d1), .en(en1), .busy(busy1), .done(done1)
  );

  serializer_tx #(.WIDTH(8), .BIT_CYCLES(3)) u_bc3 (
    .clk(clk), .reset(reset), .start(start3), .data_in(data3),
    .d(d3), .en(en3), .busy(busy3), .done(done3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One frame on u_bc1. If disturb is set, start is pulsed with other data
  // during bit 4 and data_in keeps changing; the frame must be unaffected.
  task automatic frame1(input logic [7:0] w, input logic [0:0] par_exp, input bit disturb);
    data1  = w;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    data1  = ~w;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("bit%0d_%0h", i, w), {d1, en1, busy1, done1}, {w[i], 3'b110});
      if (disturb && i == 4) begin
        start1 = 1'b1;
        data1  = 8'h5A;
      end
      if (i < 7) tick();
      start1 = 1'b0;
    end
    if (PAR == 1) begin
      tick();
      chk($sformatf("par_%0h", w), {d1, en1, busy1, done1}, {par_exp, 3'b110});
    end
    tick();
    chk($sformatf("done_%0h", w), {d1, en1, busy1, done1}, 4'b0001);
    tick();
    chk($sformatf("idle_%0h", w), {d1, en1, busy1, done1}, 4'b0000);
    tick();
    chk($sformatf("nofollow_%0h", w), {d1, en1, busy1, done1}, 4'b0000);
  endtask

  initial begin
    reset  = 1'b1;
    start1 = 1'b0;
    start3 = 1'b0;
    data1  = 8'h00;
    data3  = 8'h00;
    #23;
    chk("rst_bc1", {d1, en1, busy1, done1}, 4'b0000);
    chk("rst_bc3", {d3, en3, busy3, done3}, 4'b0000);

    // Release just after an edge; the very next edge accepts start.
    @(posedge clk);
    #1;
    reset = 1'b0;
    // A5 -> 1,0,1,0,0,1,0,1 ; even parity 0
    frame1(8'hA5, 1'b0, 1'b0);
    // Start pulsed at bit 4 with other data must be ignored; 3C parity 0
    frame1(8'h3C, 1'b0, 1'b1);
    // 07 -> parity 1 ; 03 -> parity 0
    frame1(8'h07, 1'b1, 1'b0);
    frame1(8'h03, 1'b0, 1'b0);

    // BIT_CYCLES=3, data 01: d=1 for 3 cycles, then 0 for 21 cycles
    data3  = 8'h01;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    data3  = 8'hFF;
    for (int c = 0; c < 24; c++) begin
      chk($sformatf("bc3_c%0d", c), {d3, en3, busy3, done3}, {(c < 3) ? 1'b1 : 1'b0, 3'b110});
      if (c < 23) tick();
    end
    if (PAR == 1) begin
      for (int c = 0; c < 3; c++) begin
        tick();
        chk($sformatf("bc3_par%0d", c), {d3, en3, busy3, done3}, 4'b1110);
      end
    end
    tick();
    chk("bc3_done", {d3, en3, busy3, done3}, 4'b0001);
    tick();
    chk("bc3_idle", {d3, en3, busy3, done3}, 4'b0000);

    // Asynchronous reset between edges during bit 5 of an FF frame.
    data1  = 8'hFF;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("pre_abort_bit5", {d1, en1, busy1, done1}, 4'b1110);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_immediate", {d1, en1, busy1, done1}, 4'b0000);
    #3;
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("abort_quiet%0d", i), {d1, en1, busy1, done1}, 4'b0000);
    end
    // A full frame after the abort; 96 parity 0
    frame1(8'h96, 1'b0, 1'b0);

    // start held high for 30 cycles: frames repeat every 10 (+1 with parity).
    data1  = 8'h81;
    start1 = 1'b1;
    for (int t = 1; t <= 30; t++) begin
      int ph;
      logic [3:0] exp;
      tick();
      ph = (t - 1) % (10 + PAR);
      if (ph < 8)
        exp = {data1[ph], 3'b110};
      else if (ph < 8 + PAR)
        exp = 4'b0110; // parity of 81 is 0
      else if (ph == 8 + PAR)
        exp = 4'b0001;
      else
        exp = 4'b0000;
      chk($sformatf("hold_t%0d", t), {d1, en1, busy1, done1}, {28'd0, exp});
    end
    start1 = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    chk("hold_drained", {d1, en1, busy1, done1}, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serializer_tx.md
SERIALIZER_TX -- requirements
Module: serializer_tx

Interface
REQ-001 Parameter WIDTH, default 8, number of data bits per frame; legal range 2..16.
REQ-002 Parameter BIT_CYCLES, default 1, clock cycles each serial bit is held; legal range 1..16.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request to send; sampled on rising edge of clk.
REQ-006 data_in  input  WIDTH  parallel word to serialize; sampled only when start is accepted.
REQ-007 d  output  1  serial data bit, LSB first, registered.
REQ-008 en  output  1  bit-valid strobe for the downstream enable flip-flop receiver, registered.
REQ-009 busy  output  1  high while a frame is on the line, registered.
REQ-010 done  output  1  one-cycle pulse after the last bit of a frame, registered.

Function
REQ-011 The FSM SHALL have exactly four states: IDLE, SHIFT, PARITY, DONE; encoding is free.
REQ-012 In IDLE, start=1 at a rising edge SHALL latch data_in into an internal shift register and move to SHIFT on that same edge.
REQ-013 On the accepting edge, d SHALL become data_in[0] and en and busy SHALL become 1 (zero-cycle latency after the edge).
REQ-014 In SHIFT, each bit SHALL be held on d with en=1 for exactly BIT_CYCLES cycles; bits go out in order data_in[0]..data_in[WIDTH-1].
REQ-015 A cycle counter SHALL count 0..BIT_CYCLES-1 and wrap to 0 at each bit boundary; a bit counter SHALL count 0..WIDTH-1.
REQ-016 After bit WIDTH-1 completes, the FSM SHALL go to PARITY if PARITY_EN is defined, otherwise directly to DONE.
REQ-017 In DONE (exactly one cycle), done=1, en=0, d=0, busy=0; the next state SHALL be IDLE.
REQ-018 In IDLE, d=0, en=0, busy=0, done=0.
REQ-019 start asserted in SHIFT, PARITY or DONE SHALL be ignored and SHALL NOT alter the latched word.
REQ-020 start held high continuously SHALL start a new frame on the first IDLE edge after DONE (one idle cycle minimum between frames).
REQ-021 Changes of data_in after acceptance SHALL NOT affect the frame in progress.
REQ-022 en SHALL never be 1 outside SHIFT and PARITY; en and done SHALL never be 1 in the same cycle.

Reset
REQ-023 reset=1 SHALL force IDLE, clear all counters and the shift register, and drive d=0, en=0, busy=0, done=0 immediately, independent of clk.
REQ-024 reset asserted mid-frame SHALL abort the frame with no done pulse; after release the block SHALL wait in IDLE for a new start.
REQ-025 start high on the first edge after reset release SHALL be accepted normally.

Configuration
REQ-026 Macro PARITY_EN: when defined, PARITY state SHALL send one extra bit, even parity (XOR of all WIDTH data bits), for BIT_CYCLES cycles with en=1, busy=1.
REQ-027 Without PARITY_EN, PARITY SHALL be unreachable and a frame SHALL be WIDTH*BIT_CYCLES en-high cycles followed by DONE.

Verification
REQ-028 WIDTH=8, BIT_CYCLES=1, no macro, data_in=8'hA5, start one cycle -> d sequence 1,0,1,0,0,1,0,1 with en=1 for 8 cycles, then done=1 for 1 cycle.
REQ-029 BIT_CYCLES=3, data_in=8'h01 -> d=1 for 3 cycles, then d=0 for 21 cycles, en=1 for 24 cycles total, then done pulse.
REQ-030 PARITY_EN defined, data_in=8'h07 -> 8 data bits then parity bit d=1, en=1 for 9 cycles, then done; 8'h03 -> parity bit 0.
REQ-031 start pulsed at bit 4 of a frame with different data_in -> frame output unchanged, no second frame starts.
REQ-032 reset asserted asynchronously between clock edges at bit 5 -> d, en, busy drop to 0 immediately, no done pulse; a new start after release sends a full frame.
REQ-033 start held high for 30 cycles, BIT_CYCLES=1, no macro -> back-to-back frames separated by DONE and one IDLE cycle (10-cycle period).
